// File: rtl/moving_avg_divider.sv
// ---------------------------------------------------------------------------
// moving_avg_divider
//
// Turns the running sum of a sample window into its average.
// The block uses a bit-serial restoring divider with one quotient bit per
// clock, so a division takes SUM_W cycles.
// Divide-by-zero is flagged rather than computed.
//
// Optional feature macro: AVG_ROUND_EN
//   - Defined:   the average is rounded half-up (2*REM >= N) before saturation.
//   - Undefined: the average is the truncated quotient.
//
// Ports
//   CLK    in   clock; all state updates on the rising edge
//   RESET  in   synchronous, active-high reset
//   Tsum   in   [SUM_W-1:0] running sum (dividend)
//   N      in   [3:0] number of valid samples (divisor), 0..14
//   START  in   request one division; only looked at in IDLE
//   BUSY   out  high while a request is in flight (DIV, FIN)
//   DONE   out  one-cycle pulse when AVG/REM/DIV0 are updated
//   AVG    out  [AVG_W-1:0] quotient, saturated to 2^AVG_W-1
//   REM    out  [3:0] true remainder Tsum mod N
//   DIV0   out  set when the accepted request had N = 0
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for START; result registers hold the last answer
// DIV   | one restoring-division step per edge, SUM_W steps in total
// FIN   | results registered, DONE pulses; for N=0 the first FIN cycle
//       | loads the divide-by-zero result, and the second cycle pulses DONE
// ---------------------------------------------------------------------------
module moving_avg_divider #(
    parameter int SUM_W = 16,
    parameter int AVG_W = 12
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [SUM_W-1:0] Tsum,
    input  logic [3:0]       N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic [AVG_W-1:0] AVG,
    output logic [3:0]       REM,
    output logic             DIV0
);

    localparam logic [4:0] LAST_CNT = 5'(SUM_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SUM_W-1:0] dividend;
    logic [SUM_W-1:0] quot;
    logic [3:0]       divisor;
    logic [3:0]       rem_part;
    logic [4:0]       cnt;
    // Set once AVG/REM/DIV0 carry the new answer; DONE is FIN qualified by it.
    logic             res_valid;

    logic [4:0]       rem_shift;
    logic             step_ge;
    logic [3:0]       rem_step;
    logic [SUM_W-1:0] quot_step;
    logic             last_step;
    logic             round_up;
    logic [SUM_W:0]   q_ext;
    logic [AVG_W-1:0] avg_final;

    // One restoring step.
    // The partial remainder is always below the divisor (at most 14), so the
    // shifted value fits in 5 bits and the restored remainder fits in 4 bits.
    always_comb begin
        rem_shift = {rem_part, dividend[SUM_W-1]};
        step_ge   = (rem_shift >= {1'b0, divisor});
        rem_step  = step_ge ? 4'(rem_shift - {1'b0, divisor}) : rem_shift[3:0];
        quot_step = {quot[SUM_W-2:0], step_ge};
        last_step = (cnt == LAST_CNT);
    end

    // Final average, built from the last step's outputs.
    // One extra bit is kept so that a rounding carry out of the top is still
    // caught by the saturation check.
    always_comb begin
`ifdef AVG_ROUND_EN
        round_up = ({rem_step, 1'b0} >= {1'b0, divisor});
`else
        round_up = 1'b0;
`endif
        q_ext     = {1'b0, quot_step} + {{SUM_W{1'b0}}, round_up};
        avg_final = (|q_ext[SUM_W:AVG_W]) ? '1 : q_ext[AVG_W-1:0];
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_next = (N == 4'd0) ? FIN : DIV;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                if (res_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        BUSY = (state != IDLE);
        DONE = (state == FIN) && res_valid;
    end

    // Datapath and result registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dividend  <= '0;
            quot      <= '0;
            divisor   <= '0;
            rem_part  <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            AVG       <= '0;
            REM       <= '0;
            DIV0      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        dividend  <= Tsum;
                        divisor   <= N;
                        quot      <= '0;
                        rem_part  <= '0;
                        cnt       <= '0;
                        res_valid <= 1'b0;
                    end
                end
                DIV: begin
                    dividend <= {dividend[SUM_W-2:0], 1'b0};
                    rem_part <= rem_step;
                    quot     <= quot_step;
                    cnt      <= cnt + 5'd1;
                    if (last_step) begin
                        AVG       <= avg_final;
                        REM       <= rem_step;
                        DIV0      <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                FIN: begin
                    if (!res_valid) begin
                        AVG       <= '0;
                        REM       <= '0;
                        DIV0      <= 1'b1;
                        res_valid <= 1'b1;
                    end else begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_moving_avg_divider.sv
module tb_moving_avg_divider;

    localparam int SUM_W   = 16;
    localparam int AVG_W   = 12;
    localparam int AVG_MAX = (1 << AVG_W) - 1;
    localparam int BUDGET  = 40;

    logic             CLK;
    logic             RESET;
    logic [SUM_W-1:0] Tsum;
    logic [3:0]       N;
    logic             START;
    logic             BUSY;
    logic             DONE;
    logic [AVG_W-1:0] AVG;
    logic [3:0]       REM;
    logic             DIV0;

    typedef struct {
        int avg;
        int rem;
        int div0;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    moving_avg_divider #(.SUM_W(SUM_W), .AVG_W(AVG_W)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .Tsum (Tsum),
        .N    (N),
        .START(START),
        .BUSY (BUSY),
        .DONE (DONE),
        .AVG  (AVG),
        .REM  (REM),
        .DIV0 (DIV0)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int tsum, input int n);
        exp_t e;
        int   q;
        int   r;
        if (n == 0) begin
            e.avg  = 0;
            e.rem  = 0;
            e.div0 = 1;
            e.lat  = 1;
        end else begin
            q = tsum / n;
            r = tsum % n;
`ifdef AVG_ROUND_EN
            if (2 * r >= n) q++;
`endif
            if (q > AVG_MAX) q = AVG_MAX;
            e.avg  = q;
            e.rem  = r;
            e.div0 = 0;
            e.lat  = SUM_W;
        end
        return e;
    endfunction

    // Drive a request so that it is accepted at the next edge.
    // After that edge, scramble the inputs and check that the previous
    // results are still held.
    task automatic issue(input int tsum, input int n);
        Tsum  = SUM_W'(tsum);
        N     = 4'(n);
        START = 1'b1;
        sb.push_back(model(tsum, n));
        @(posedge CLK);
        #1;
        START = 1'b0;
        Tsum  = SUM_W'($urandom);
        N     = 4'($urandom_range(0, 14));
        check("busy_on_accept", BUSY, 1);
        check("done_low_on_accept", DONE, 0);
        check("avg_held", AVG, last.avg);
        check("rem_held", REM, last.rem);
        check("div0_held", DIV0, last.div0);
    endtask

    // Wait (bounded) for DONE, counting edges since acceptance.
    // Then compare the result against the scoreboard head.
    task automatic wait_done(input int edges_so_far);
        int   lat;
        exp_t e;
        lat = edges_so_far;
        while (lat < BUDGET) begin
            @(posedge CLK);
            #1;
            lat++;
            if (DONE === 1'b1) break;
        end
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("done_latency", lat, e.lat);
            check("avg", AVG, e.avg);
            check("rem", REM, e.rem);
            check("div0", DIV0, e.div0);
            check("busy_in_fin", BUSY, 1);
            last = e;
        end
        @(posedge CLK);
        #1;
        check("done_one_cycle", DONE, 0);
        check("busy_idle", BUSY, 0);
    endtask

    task automatic expect_no_done(input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) seen++;
        end
        check("no_extra_done", seen, 0);
    endtask

    initial begin
        exp_t dropped;
        last.avg  = 0;
        last.rem  = 0;
        last.div0 = 0;
        last.lat  = 0;
        RESET = 1'b1;
        START = 1'b1;
        Tsum  = 16'd1400;
        N     = 4'd14;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_avg", AVG, 0);
        check("rst_rem", REM, 0);
        check("rst_div0", DIV0, 0);
        RESET = 1'b0;
        START = 1'b0;
        @(posedge CLK);
        #1;

        issue(1400, 14);  wait_done(0);
        issue(1001, 3);   wait_done(0);
        issue(5000, 1);   wait_done(0);
        issue(777, 0);    wait_done(0);
        issue(65535, 14); wait_done(0);
        issue(100, 7);    wait_done(0);
        issue(13, 14);    wait_done(0);
        issue(0, 5);      wait_done(0);
        issue(4095, 1);   wait_done(0);
        issue(49151, 12); wait_done(0);

        // START re-pulsed mid-division must be ignored.
        issue(1001, 3);
        repeat (4) @(posedge CLK);
        #1;
        Tsum  = 16'd28;
        N     = 4'd14;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(5);
        expect_no_done(20);

        // Reset at k+8 aborts the division.
        issue(1400, 14);
        repeat (7) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_avg", AVG, 0);
        check("abort_rem", REM, 0);
        check("abort_div0", DIV0, 0);
        dropped = sb.pop_front();
        last.avg  = 0;
        last.rem  = 0;
        last.div0 = 0;
        expect_no_done(20);
        issue(1001, 3);   wait_done(0);
        issue(0, 0);      wait_done(0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moving_avg_divider.md
MOVING_AVG_DIVIDER -- requirements
Module: moving_avg_divider

Interface
REQ-001 Parameter SUM_W, default 16, width of the incoming running-sum operand.
REQ-002 Parameter AVG_W, default 12, width of the average result; it matches the sample width of the upstream sample window.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET  input  1  reset, synchronous and active-high.
REQ-005 Tsum  input  SUM_W  running sum of window samples, from the upstream sample window.
REQ-006 N  input  4  count of valid samples in Tsum, range 0..14.
REQ-007 START  input  1  request one division; sampled only in IDLE.
REQ-008 BUSY  output  1  high while a division is in progress.
REQ-009 DONE  output  1  one-cycle pulse when the results are valid.
REQ-010 AVG  output  AVG_W  quotient Tsum/N, saturated.
REQ-011 REM  output  4  remainder Tsum mod N.
REQ-012 DIV0  output  1  set when the accepted request had N=0.

Function
REQ-013 The FSM SHALL have three states: IDLE, DIV and FIN; the reset state is IDLE.
REQ-014 In IDLE, START=1 at edge k SHALL latch Tsum and N, clear the partial remainder and the 5-bit iteration counter, and enter DIV (N!=0) or FIN (N=0).
REQ-015 In DIV, each edge SHALL perform one restoring-division step (shift the remainder left with the next dividend MSB, subtract the divisor if it is not negative, shift in the quotient bit), SUM_W steps in total.
REQ-016 After step SUM_W (edge k+SUM_W), the block SHALL register AVG, REM and DIV0=0 and enter FIN.
REQ-017 In FIN, DONE SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-018 The DONE latency SHALL be: DONE high in the cycle after edge k+SUM_W (N!=0), or in the cycle after edge k+1 (N=0).
REQ-019 BUSY SHALL be 1 in DIV and FIN and 0 in IDLE.
REQ-020 START SHALL be ignored in DIV and FIN, with no queuing.
REQ-021 Tsum and N changes after acceptance SHALL NOT affect the in-flight result.
REQ-022 If the SUM_W-bit quotient exceeds 2^AVG_W-1, AVG SHALL saturate to 2^AVG_W-1; REM SHALL stay the true remainder.
REQ-023 If N=0, then AVG=0, REM=0 and DIV0=1.
REQ-024 AVG, REM and DIV0 SHALL hold their values until the next DONE, and SHALL NOT change on acceptance.

Reset
REQ-025 RESET=1 SHALL force IDLE, BUSY=0, DONE=0, AVG=0, REM=0, DIV0=0 and counter=0 at the next edge, and SHALL take priority over START.
REQ-026 RESET during DIV or FIN SHALL abort the division with no DONE pulse.

Configuration
REQ-027 With AVG_ROUND_EN defined, AVG SHALL be rounded half-up: if 2*REM >= N, the quotient is incremented before saturation; latency is unchanged and REM reports the untruncated remainder.
REQ-028 Without AVG_ROUND_EN, AVG SHALL be the truncated quotient.

Verification
REQ-029 Tsum=1400, N=14, START at edge k -> BUSY 1 from k; DONE in the cycle after k+16; AVG=100, REM=0, DIV0=0.
REQ-030 Tsum=1001, N=3 -> AVG=333, REM=2; with AVG_ROUND_EN, AVG=334.
REQ-031 Tsum=5000, N=1 -> AVG=4095 (saturated), REM=0.
REQ-032 Tsum=777, N=0 -> DONE in the cycle after k+1; AVG=0, REM=0, DIV0=1.
REQ-033 START re-pulsed at k+5 with Tsum=28, N=14 -> ignored; the first result completes; no second DONE.
REQ-034 RESET at k+8 mid-division -> next edge IDLE, all outputs 0, no DONE; a new START then yields a correct result.
